// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM profile sequencer.
package pwm_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ENABLE,
    S_GAP,
    S_POLL,
    S_STOP,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    A_IDLE,
    A_SETUP,
    A_ACCESS
  } apb_state_e;

  // Peripheral register map
  localparam logic [5:0] REG_CTRL = 6'h00;
  localparam logic [5:0] REG_T1D  = 6'h04;
  localparam logic [5:0] REG_T1C  = 6'h08;
  localparam logic [5:0] REG_T2D  = 6'h0C;
  localparam logic [5:0] REG_T2C  = 6'h10;
  localparam logic [5:0] REG_T3D  = 6'h14;
  localparam logic [5:0] REG_T3C  = 6'h18;

  localparam int unsigned FIELD_CNT = 6;

  localparam logic [31:0] DUTY_RST = 32'd20;
  localparam logic [31:0] CNT_RST  = 32'd1;
  localparam logic [31:0] CTRL_EN  = 32'h1;
  localparam logic [31:0] CTRL_OFF = 32'h0;

  // Field n lives at T1D + 4*n
  function automatic logic [5:0] field_addr(input logic [2:0] field);
    return REG_T1D + {1'b0, field, 2'b00};
  endfunction

endpackage

// File: rtl/pwm_apb_master.sv
// Single-transfer APB master: one req pulse -> SETUP, ACCESS until pready, ack pulse.
module pwm_apb_master
  import pwm_seq_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [5:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic        write_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [5:0]  paddr_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i
);

  apb_state_e st_q;

  // Transfer engine; address/data/direction are held from SETUP to completion
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q      <= A_IDLE;
      ack_o     <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (st_q)
        A_IDLE: begin
          if (req_i) begin
            paddr_o  <= addr_i;
            pwdata_o <= wdata_i;
            pwrite_o <= write_i;
            psel_o   <= 1'b1;
            st_q     <= A_SETUP;
          end
        end
        A_SETUP: begin
          penable_o <= 1'b1;
          st_q      <= A_ACCESS;
        end
        A_ACCESS: begin
          if (pready_i) begin
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            ack_o     <= 1'b1;
            err_o     <= pslverr_i;
            rdata_o   <= prdata_i;
            st_q      <= A_IDLE;
          end
        end
        default: st_q <= A_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pwm_seq_scheduler.sv
// Loads PWM profiles over APB, enables each, polls until it finishes.
module pwm_seq_scheduler
  import pwm_seq_pkg::*;
#(
  parameter int unsigned NUM_PROF = 4,
  parameter int unsigned POLL_GAP = 16,
  parameter logic [23:0] TIMEOUT  = 24'd1048575
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        prof_we_i,
  input  logic [1:0]  prof_idx_i,
  input  logic [2:0]  prof_field_i,
  input  logic [31:0] prof_data_i,
  input  logic        start_i,
  input  logic [2:0]  num_prof_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  cur_prof_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [5:0]  paddr_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i
);

  localparam logic [2:0]  NP_MAX  = 3'(NUM_PROF);
  localparam logic [15:0] GAP_LIM = 16'(POLL_GAP);
  localparam logic [2:0]  LAST_F  = 3'(FIELD_CNT - 1);

  state_e      state_q;
  logic [31:0] tbl [NUM_PROF][FIELD_CNT];
  logic [2:0]  nprof_q;
  logic [1:0]  prof_q;
  logic [2:0]  field_q;
  logic [15:0] gap_cnt_q;
  logic [23:0] tmo_cnt_q;
  logic        tmo_run_q;
  logic        stop_req_q;
  logic        err_q;
  logic        req_q;
  logic        xfer_q;
  logic        write_q;
  logic [5:0]  addr_q;
  logic [31:0] wdata_q;
  logic        m_ack;
  logic        m_err;
  logic [31:0] m_rdata;
  logic        stop_now;
  logic        last_prof;

  assign stop_now   = stop_req_q | abort_i;
  assign last_prof  = ({1'b0, prof_q} == (nprof_q - 3'd1));
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign err_o      = err_q;
  assign cur_prof_o = prof_q;

  // Profile table: writable only while idle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned p = 0; p < NUM_PROF; p++)
        for (int unsigned f = 0; f < FIELD_CNT; f++)
          tbl[p][f] <= f[0] ? CNT_RST : DUTY_RST;
    end else if (prof_we_i && state_q == S_IDLE && prof_field_i <= LAST_F
                 && 32'(prof_idx_i) < NUM_PROF) begin
      tbl[prof_idx_i][prof_field_i] <= prof_data_i;
    end
  end

  // Sequencer FSM. Abort and timeout share one stop request so that both in
  // the same cycle yield a single STOP; it is acted on only between transfers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      nprof_q    <= '0;
      prof_q     <= '0;
      field_q    <= '0;
      gap_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      tmo_run_q  <= 1'b0;
      stop_req_q <= 1'b0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
      xfer_q     <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      req_q <= 1'b0;
      if (m_ack) xfer_q <= 1'b0;
      if (state_q != S_IDLE && abort_i) stop_req_q <= 1'b1;

      if (tmo_run_q) begin
        if (tmo_cnt_q >= TIMEOUT) begin
          err_q      <= 1'b1;
          stop_req_q <= 1'b1;
          tmo_run_q  <= 1'b0;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + 24'd1;
        end
      end

      case (state_q)
        S_IDLE: begin
          stop_req_q <= 1'b0;
          tmo_run_q  <= 1'b0;
          if (start_i) begin
            if (num_prof_i == 3'd0 || num_prof_i > NP_MAX) begin
              err_q <= 1'b1;
            end else begin
              err_q   <= 1'b0;
              nprof_q <= num_prof_i;
              prof_q  <= '0;
              field_q <= '0;
              state_q <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (!xfer_q) begin
            if (stop_now) begin
              state_q <= S_STOP;
            end else begin
              req_q   <= 1'b1;
              xfer_q  <= 1'b1;
              write_q <= 1'b1;
              addr_q  <= field_addr(field_q);
              wdata_q <= tbl[prof_q][field_q];
            end
          end else if (m_ack) begin
            if (m_err) begin
              err_q   <= 1'b1;
              state_q <= S_STOP;
            end else if (field_q == LAST_F) begin
              state_q <= S_ENABLE;
            end else begin
              field_q <= field_q + 3'd1;
            end
          end
        end

        S_ENABLE: begin
          if (!xfer_q) begin
            if (stop_now) begin
              state_q <= S_STOP;
            end else begin
              req_q   <= 1'b1;
              xfer_q  <= 1'b1;
              write_q <= 1'b1;
              addr_q  <= REG_CTRL;
              wdata_q <= CTRL_EN;
            end
          end else if (m_ack) begin
            if (m_err) begin
              err_q   <= 1'b1;
              state_q <= S_STOP;
            end else begin
              tmo_cnt_q <= '0;
              tmo_run_q <= 1'b1;
              gap_cnt_q <= 16'd1;
              state_q   <= S_GAP;
            end
          end
        end

        S_GAP: begin
          if (stop_now) begin
            state_q <= S_STOP;
          end else if (gap_cnt_q >= GAP_LIM) begin
            state_q <= S_POLL;
          end else begin
            gap_cnt_q <= gap_cnt_q + 16'd1;
          end
        end

        S_POLL: begin
          if (!xfer_q) begin
            if (stop_now) begin
              state_q <= S_STOP;
            end else begin
              req_q   <= 1'b1;
              xfer_q  <= 1'b1;
              write_q <= 1'b0;
              addr_q  <= REG_CTRL;
              wdata_q <= '0;
            end
          end else if (m_ack) begin
            if (m_err) begin
              err_q   <= 1'b1;
              state_q <= S_STOP;
            end else if (m_rdata[0]) begin
              gap_cnt_q <= 16'd1;
              state_q   <= S_GAP;
            end else begin
              tmo_run_q <= 1'b0;
              if (last_prof) begin
                state_q <= S_DONE;
              end else begin
                prof_q  <= prof_q + 2'd1;
                field_q <= '0;
                state_q <= S_LOAD;
              end
            end
          end
        end

        S_STOP: begin
          tmo_run_q <= 1'b0;
          if (!xfer_q) begin
            req_q   <= 1'b1;
            xfer_q  <= 1'b1;
            write_q <= 1'b1;
            addr_q  <= REG_CTRL;
            wdata_q <= CTRL_OFF;
          end else if (m_ack) begin
            if (m_err) err_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end

        S_DONE: state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase
    end
  end

  pwm_apb_master u_apb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_q),
    .addr_i    (addr_q),
    .wdata_i   (wdata_q),
    .write_i   (write_q),
    .ack_o     (m_ack),
    .rdata_o   (m_rdata),
    .err_o     (m_err),
    .psel_o    (psel_o),
    .penable_o (penable_o),
    .pwrite_o  (pwrite_o),
    .paddr_o   (paddr_o),
    .pwdata_o  (pwdata_o),
    .prdata_i  (prdata_i),
    .pready_i  (pready_i),
    .pslverr_i (pslverr_i)
  );

endmodule

// File: doc/pwm_seq_scheduler.md
PWM_SEQ_SCHEDULER -- requirements
Module: pwm_seq_scheduler

Interface
REQ-001 The parameter list SHALL be: NUM_PROF, 4, number of profile slots (1..4).
REQ-002 The parameter list SHALL include: POLL_GAP, 16, idle cycles between status polls (>=1).
REQ-003 The parameter list SHALL include: TIMEOUT, 24'd1048575, maximum cycles per profile from enable-write to done.
REQ-004 Clock and reset SHALL be one clock and a synchronous, active-high reset.
REQ-005 Port clk_i, input, 1: the only clock; all logic is rising-edge.
REQ-006 Port rst_i, input, 1: synchronous active-high reset.
REQ-007 Port prof_we_i, input, 1: profile table write strobe.
REQ-008 Port prof_idx_i, input, 2: profile slot.
REQ-009 Port prof_field_i, input, 3: field 0..5 = T1 duty, T1 count, T2 duty, T2 count, T3 duty, T3 count.
REQ-010 Port prof_data_i, input, 32: field value.
REQ-011 Port start_i, input, 1: pulse; run profiles 0..num_prof_i-1.
REQ-012 Port num_prof_i, input, 3: profile count, sampled at start.
REQ-013 Port abort_i, input, 1: pulse; stop the sequence safely.
REQ-014 Port busy_o, output, 1: a sequence is in progress.
REQ-015 Port done_o, output, 1: one-cycle pulse when the sequence ends normally.
REQ-016 Port err_o, output, 1: sticky error; cleared by start.
REQ-017 Port cur_prof_o, output, 2: profile currently running.
REQ-018 APB master ports SHALL be: psel_o out 1; penable_o out 1; pwrite_o out 1; paddr_o out 6; pwdata_o out 32; prdata_i in 32; pready_i in 1; pslverr_i in 1.

Function
REQ-019 A table write SHALL take effect when prof_we_i=1, busy_o=0 and prof_field_i<=5; it is ignored otherwise.
REQ-020 start_i SHALL be ignored while busy_o=1.
REQ-021 A start with num_prof_i=0 or num_prof_i>NUM_PROF SHALL set err_o and emit no APB traffic.
REQ-022 Each APB transfer SHALL use a SETUP cycle (psel=1, penable=0), then ACCESS (psel=1, penable=1) held until pready_i=1.
REQ-023 Address, data and pwrite SHALL be stable from SETUP through completion, and psel_o SHALL drop the cycle after pready_i.
REQ-024 The per-profile sequence SHALL be:
  - six writes of fields 0..5 to paddr 0x04,0x08,...,0x18;
  - a write of 0x1 to 0x00 (enable plus counter reset);
  - POLL_GAP idle cycles, then a read of 0x00;
  - repeat gap+read while prdata_i[0]=1;
  - when prdata_i[0]=0, advance to the next profile.
REQ-025 States SHALL be IDLE, LOAD (writes), ENABLE, GAP, POLL, STOP, DONE.
REQ-026 State transitions SHALL be:
  - IDLE->LOAD on a valid start;
  - LOAD->ENABLE after the 6th write;
  - ENABLE->GAP;
  - GAP->POLL when the gap counter reaches POLL_GAP;
  - POLL->GAP while enable=1;
  - POLL->LOAD for the next profile;
  - POLL->DONE after the last profile;
  - DONE->IDLE after 1 cycle.
REQ-027 done_o SHALL assert in the DONE cycle.
REQ-028 A timeout counter SHALL reset at ENABLE completion and count every cycle until the profile's done.
REQ-029 When the timeout counter reaches TIMEOUT, the block SHALL set err_o and go to STOP.
REQ-030 pslverr_i=1 on any completing transfer SHALL set err_o and go to STOP; if the failing transfer is itself the STOP write, go to IDLE.
REQ-031 abort_i SHALL be latched; the in-flight transfer completes, then the block goes to STOP.
REQ-032 An abort in IDLE SHALL be ignored.
REQ-033 STOP SHALL write 0x0 to 0x00, then go to IDLE with no done_o.
REQ-034 abort_i and a timeout in the same cycle SHALL result in a single STOP with err_o=1.
REQ-035 busy_o SHALL be 1 in every state except IDLE.
REQ-036 cur_prof_o SHALL hold its last value in IDLE.
REQ-037 The poll and timeout counters SHALL saturate and never wrap.

Reset
REQ-038 While rst_i=1, state SHALL be IDLE and all outputs SHALL be 0, including paddr_o, pwdata_o and cur_prof_o.
REQ-039 Reset SHALL clear the abort latch and all counters.
REQ-040 The profile table SHALL reset to duty=20 and count=1 for every stage.
REQ-041 Reset mid-transfer SHALL drop psel_o/penable_o the next cycle; no STOP write is issued.

Structure
REQ-042 Package pwm_seq_pkg SHALL hold the state enum, the register offsets (CTRL=6'h00, T1D=6'h04 ... T3C=6'h18) and the field count constant 6.
REQ-043 A sub-module pwm_apb_master SHALL be used: a single-transfer engine with req/addr/wdata/write in and ack/rdata/err out.
REQ-044 The scheduler FSM SHALL drive pwm_apb_master only.

Verification
REQ-045 Load profile 0 = {50,2,25,3,75,1}, start with num_prof_i=1, zero-wait slave: bench sees writes 0x04=50 ... 0x18=1, then 0x00=1, then polls; slave returns bit0=0 on the 3rd read -> done_o one pulse, busy_o falls, err_o=0.
REQ-046 Slave inserts 3 wait states per transfer: psel/penable/paddr/pwdata stay stable until pready_i, with exactly 6+1+N transfers per profile.
REQ-047 num_prof_i=2: profile 1 writes begin only after the profile-0 read shows bit0=0; cur_prof_o goes 0->1.
REQ-048 Slave keeps bit0=1 forever, TIMEOUT=200: err_o=1 at ~200 cycles after enable, STOP write 0x00=0, no done_o.
REQ-049 abort_i pulsed during the 3rd LOAD write with wait states: that write completes, the next transfer is 0x00=0, then IDLE.
REQ-050 pslverr_i=1 on the 0x08 write: err_o=1, STOP write issued; start with num_prof_i=5: err_o=1, psel_o never asserts.
